cnt_modn: RTL and testbench

CNT_MODN -- requirements
Module: cnt_modn

---
 rtl/cnt_pkg.sv | 7 +
 rtl/cnt_prescale.sv | 20 ++
 rtl/cnt_modn.sv | 60 ++++++
 tb/tb_cnt_modn.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants and width helper for the modulo counter
package cnt_pkg;
    localparam int PRESCALE_DEF = 1;
    function automatic int min_w(input int mod);
        return (mod <= 2) ? 1 : $clog2(mod);
    endfunction
endpackage

// File: rtl/cnt_prescale.sv
// cnt_prescale: divides qualified requests down to count steps
module cnt_prescale #(
    parameter int PRESCALE = cnt_pkg::PRESCALE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic clr,
    output logic step
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] pcnt;
    assign step = req && pcnt == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcnt <= '0;
        else if (clr) pcnt <= '0;
        else if (req) pcnt <= step ? '0 : pcnt + 1'b1;
    end
endmodule

// File: rtl/cnt_modn.sv
// cnt_modn: prescaled up/down modulo-MOD counter with wrap/saturate and boundary pulses
module cnt_modn
    import cnt_pkg::*;
#(
    parameter int MOD      = 4,
    parameter int W        = 2,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         sat,
    output logic [W-1:0] cnt,
    output logic         tc,
    output logic         bc
);
    if (MOD < 2 || PRESCALE < 1 || W < min_w(MOD)) begin : g_bad_param
        $fatal(1, "cnt_modn: illegal MOD/W/PRESCALE");
    end
    localparam logic [W-1:0] TOP = W'(MOD - 1);
    logic up, dn, req, step, at_top, at_bot;
    logic [W-1:0] cnt_nxt;
    assign up = inc & ~dec;
    assign dn = dec & ~inc;
    assign req = ena & ~load & (up | dn);
    assign at_top = cnt == TOP;
    assign at_bot = cnt == '0;
    assign cnt_nxt = !step ? cnt :
                     up ? (at_top ? (sat ? cnt : '0) : cnt + 1'b1) :
                          (at_bot ? (sat ? cnt : TOP) : cnt - 1'b1);
    cnt_prescale #(.PRESCALE(PRESCALE)) u_pre (
        .clk (clk),
        .rst (rst),
        .req (req),
        .clr (ena & load),
        .step(step)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b0;
            bc  <= 1'b0;
        end else if (!ena) begin
            tc <= 1'b0;
            bc <= 1'b0;
        end else if (load) begin
            cnt <= (load_val > TOP) ? TOP : load_val;
            tc  <= 1'b0;
            bc  <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            tc  <= step & up & at_top;
            bc  <= step & dn & at_bot;
        end
    end
endmodule

// File: tb/tb_cnt_modn.sv
// tb_cnt_modn: directed scoreboard bench over four counter configurations
module tb_cnt_modn;
    logic clk = 0, rst = 1, ena = 0, inc = 0, dec = 0, load = 0, sat = 0;
    logic [3:0] lv = 0;
    logic [1:0] c0;
    logic [3:0] c1, c2;
    logic [2:0] c3;
    logic [3:0] tcs, bcs;
    int cyc = 0, checks = 0, errors = 0;
    typedef struct { int cyc; int id; int c; bit t; bit b; } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnt_modn #(.MOD(4), .W(2), .PRESCALE(1)) u0 (.clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec),
        .load(load), .load_val(lv[1:0]), .sat(sat), .cnt(c0), .tc(tcs[0]), .bc(bcs[0]));
    cnt_modn #(.MOD(10), .W(4), .PRESCALE(1)) u1 (.clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec),
        .load(load), .load_val(lv), .sat(sat), .cnt(c1), .tc(tcs[1]), .bc(bcs[1]));
    cnt_modn #(.MOD(12), .W(4), .PRESCALE(3)) u2 (.clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec),
        .load(load), .load_val(lv), .sat(sat), .cnt(c2), .tc(tcs[2]), .bc(bcs[2]));
    cnt_modn #(.MOD(6), .W(3), .PRESCALE(1)) u3 (.clk(clk), .rst(rst), .ena(ena), .inc(inc), .dec(dec),
        .load(load), .load_val(lv[2:0]), .sat(sat), .cnt(c3), .tc(tcs[3]), .bc(bcs[3]));

    function automatic int cnt_of(input int id);
        return id == 0 ? int'(c0) : id == 1 ? int'(c1) : id == 2 ? int'(c2) : int'(c3);
    endfunction

    task automatic check(input string name, input int id, input int c, input bit t, input bit b);
        checks++;
        if (cnt_of(id) != c || tcs[id] != t || bcs[id] != b) begin
            errors++;
            $display("FAIL %s u%0d: cnt=%0d tc=%0b bc=%0b, required cnt=%0d tc=%0b bc=%0b",
                     name, id, cnt_of(id), tcs[id], bcs[id], c, t, b);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("cyc%0d", e.cyc), e.id, e.c, e.t, e.b);
        end
    end

    task automatic drv(input bit e, input bit i, input bit d, input bit l, input int v, input bit s,
                       input int id, input int c, input bit t, input bit b);
        @(negedge clk);
        #1;
        ena = e; inc = i; dec = d; load = l; lv = 4'(v); sat = s;
        q.push_back('{cyc + 1, id, c, t, b});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1; ena = 0; inc = 0; dec = 0; load = 0; sat = 0;
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) check("reset", k, 0, 0, 0);
        #1 rst = 0;
        // wrap up-count with tc on rollover
        drv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 2, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 3, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // down-wrap, down-saturate, up-saturate on MOD=10
        do_reset();
        drv(1, 0, 1, 0, 0, 0, 1, 9, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        drv(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        drv(1, 0, 1, 0, 0, 1, 1, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        drv(1, 0, 0, 1, 9, 1, 1, 9, 0, 0);
        drv(1, 1, 0, 0, 0, 1, 1, 9, 1, 0);
        drv(1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        drv(1, 0, 1, 0, 0, 0, 1, 9, 0, 1);
        // prescale by 3 on MOD=12
        do_reset();
        drv(1, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 1, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 2, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 2, 0, 0);
        drv(1, 0, 0, 1, 5, 0, 2, 5, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 5, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 2, 5, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 5, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 2, 6, 0, 0);
        // load priority, clamp, inc=dec on MOD=6
        do_reset();
        drv(1, 1, 0, 1, 7, 0, 3, 5, 0, 0);
        drv(1, 1, 1, 0, 0, 0, 3, 5, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 3, 0, 1, 0);
        drv(1, 0, 1, 1, 6, 0, 3, 5, 0, 0);
        drv(1, 0, 0, 1, 3, 0, 3, 3, 0, 0);
        drv(1, 0, 1, 0, 0, 0, 3, 2, 0, 0);
        // asynchronous reset mid-cycle, then ena=0 holds
        do_reset();
        drv(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 2, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 3, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1 inc = 0;
        @(posedge clk);
        #3 rst = 1;
        #1 check("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 0;
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
